axi_burst_slave_mem: RTL and testbench

//  Parametrised AXI4 burst slave with a word-addressed memory behind it. It adds FIXED/INCR/WRAP burst support, byte strobes, and SLVERR responses for bad bursts and out-of-range accesses.
//  It sits on the slave side of the interconnect as the generic memory target, with independent read and write engines.

---
 rtl/axi_burst_slave_mem.sv | 275 +++++++++++++++++++++++++++
 tb/tb_axi_burst_slave_mem.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_slave_mem.sv
// AXI4 burst slave fronting a word-addressed memory: independent read and write engines,
// FIXED/INCR/WRAP bursts, byte strobes, SLVERR for malformed bursts and out-of-range beats.
module axi_burst_slave_mem #(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter int                DEPTH     = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic [ADDR_W-1:0]   awaddr,
   input  logic [7:0]          awlen,
   input  logic [1:0]          awburst,
   input  logic                awvalid,
   output logic                awready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic                wlast,
   input  logic                wvalid,
   output logic                wready,
   output logic [1:0]          bresp,
   output logic                bvalid,
   input  logic                bready,
   input  logic [ADDR_W-1:0]   araddr,
   input  logic [7:0]          arlen,
   input  logic [1:0]          arburst,
   input  logic                arvalid,
   output logic                arready,
   output logic [DATA_W-1:0]   rdata,
   output logic [1:0]          rresp,
   output logic                rlast,
   output logic                rvalid,
   input  logic                rready
);
   localparam int BYTES = DATA_W / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE = 2'b00, W_DATA = 2'b01, W_RESP = 2'b10} w_state_t;
   typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

   // Reserved burst types and unsupported WRAP lengths run as INCR but are flagged
   function automatic logic burst_bad(input logic [7:0] len, input logic [1:0] burst);
      return (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok(len));
   endfunction

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                   input logic [7:0]        len,
                                                   input logic [1:0]        burst);
      logic [ADDR_W-1:0] inc;
      logic [ADDR_W-1:0] mask;
      logic [ADDR_W-1:0] res;
      inc  = addr + ADDR_W'(BYTES);
      mask = ((ADDR_W'(len) + ADDR_W'(1)) * ADDR_W'(BYTES)) - ADDR_W'(1);
      case (burst)
         2'b00:   res = addr;
         2'b10:   res = wrap_len_ok(len) ? ((addr & ~mask) | (inc & mask)) : inc;
         default: res = inc;
      endcase
      return res;
   endfunction

   function automatic logic in_range(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] idx;
      idx = (addr - BASE_ADDR) >> OFF_W;
      return (addr >= BASE_ADDR) && (idx < ADDR_W'(DEPTH));
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
      return IDX_W'((addr - BASE_ADDR) >> OFF_W);
   endfunction

   logic [DATA_W-1:0] mem_q [DEPTH];

   w_state_t          w_state_q;
   logic              awready_q, wready_q, bvalid_q, w_bad_q, w_err_q;
   logic [1:0]        bresp_q, w_burst_q;
   logic [7:0]        w_len_q, w_cnt_q;
   logic [ADDR_W-1:0] w_addr_q, w_addr_d;
   logic              w_beat_err_s;

   r_state_t          r_state_q;
   logic              arready_q, rvalid_q, rlast_q, r_bad_q;
   logic [1:0]        rresp_q, r_burst_q;
   logic [7:0]        r_len_q, r_cnt_q;
   logic [ADDR_W-1:0] r_addr_q, r_addr_d;
   logic [DATA_W-1:0] rdata_q;
   logic [ADDR_W-1:0] r_fetch_addr_s;
   logic              r_fetch_bad_s;
   logic [DATA_W-1:0] r_fetch_data_s;
   logic [1:0]        r_fetch_resp_s;

   // Write beat address step and per-beat error detection
   always_comb begin
      w_addr_d     = next_addr(w_addr_q, w_len_q, w_burst_q);
      w_beat_err_s = 1'b0;
      if (w_bad_q || !in_range(w_addr_q) || (wlast != (w_cnt_q == w_len_q))) begin
         w_beat_err_s = 1'b1;
      end else begin
         w_beat_err_s = 1'b0;
      end
   end

   // Write engine: address accept, data beats, response hold
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_state_q <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         w_addr_q  <= '0;
         w_len_q   <= 8'd0;
         w_burst_q <= 2'b00;
         w_bad_q   <= 1'b0;
         w_cnt_q   <= 8'd0;
         w_err_q   <= 1'b0;
      end else begin
         case (w_state_q)
            W_IDLE: begin
               if (awready_q && awvalid) begin
                  w_addr_q  <= awaddr;
                  w_len_q   <= awlen;
                  w_burst_q <= awburst;
                  w_bad_q   <= burst_bad(awlen, awburst);
                  w_cnt_q   <= 8'd0;
                  w_err_q   <= 1'b0;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
                  w_state_q <= W_DATA;
               end else begin
                  awready_q <= 1'b1;
               end
            end
            W_DATA: begin
               if (wvalid && wready_q) begin
                  w_addr_q <= w_addr_d;
                  w_cnt_q  <= w_cnt_q + 8'd1;
                  if (w_cnt_q == w_len_q) begin
                     wready_q  <= 1'b0;
                     bvalid_q  <= 1'b1;
                     bresp_q   <= (w_err_q || w_beat_err_s) ? RESP_SLVERR : RESP_OKAY;
                     w_state_q <= W_RESP;
                  end else begin
                     w_err_q <= w_err_q || w_beat_err_s;
                  end
               end
            end
            W_RESP: begin
               if (bready) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  w_state_q <= W_IDLE;
               end
            end
            default: begin
               awready_q <= 1'b0;
               wready_q  <= 1'b0;
               bvalid_q  <= 1'b0;
               w_state_q <= W_IDLE;
            end
         endcase
      end
   end

   // Memory array update; out-of-range beats are dropped
   always_ff @(posedge aclk) begin
      if ((w_state_q == W_DATA) && wvalid && wready_q && in_range(w_addr_q)) begin
         for (int b = 0; b < BYTES; b++) begin
            if (wstrb[b]) begin
               mem_q[word_idx(w_addr_q)][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   // Read fetch: first beat comes from the AR channel, later beats from the stepped address
   always_comb begin
      r_addr_d       = next_addr(r_addr_q, r_len_q, r_burst_q);
      r_fetch_addr_s = r_addr_d;
      r_fetch_bad_s  = r_bad_q;
      r_fetch_data_s = '0;
      r_fetch_resp_s = RESP_SLVERR;
      if (r_state_q == R_IDLE) begin
         r_fetch_addr_s = araddr;
         r_fetch_bad_s  = burst_bad(arlen, arburst);
      end else begin
         r_fetch_addr_s = r_addr_d;
         r_fetch_bad_s  = r_bad_q;
      end
      if (in_range(r_fetch_addr_s) && !r_fetch_bad_s) begin
         r_fetch_data_s = mem_q[word_idx(r_fetch_addr_s)];
         r_fetch_resp_s = RESP_OKAY;
      end else begin
         r_fetch_data_s = '0;
         r_fetch_resp_s = RESP_SLVERR;
      end
   end

   // Read engine: registered beats, held while the master stalls
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rresp_q   <= 2'b00;
         rdata_q   <= '0;
         r_addr_q  <= '0;
         r_len_q   <= 8'd0;
         r_burst_q <= 2'b00;
         r_bad_q   <= 1'b0;
         r_cnt_q   <= 8'd0;
      end else begin
         case (r_state_q)
            R_IDLE: begin
               if (arready_q && arvalid) begin
                  r_addr_q  <= araddr;
                  r_len_q   <= arlen;
                  r_burst_q <= arburst;
                  r_bad_q   <= r_fetch_bad_s;
                  r_cnt_q   <= 8'd0;
                  rdata_q   <= r_fetch_data_s;
                  rresp_q   <= r_fetch_resp_s;
                  rlast_q   <= (arlen == 8'd0);
                  rvalid_q  <= 1'b1;
                  arready_q <= 1'b0;
                  r_state_q <= R_DATA;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            R_DATA: begin
               if (rready) begin
                  if (rlast_q) begin
                     rvalid_q  <= 1'b0;
                     rlast_q   <= 1'b0;
                     arready_q <= 1'b1;
                     r_state_q <= R_IDLE;
                  end else begin
                     r_addr_q <= r_addr_d;
                     r_cnt_q  <= r_cnt_q + 8'd1;
                     rdata_q  <= r_fetch_data_s;
                     rresp_q  <= r_fetch_resp_s;
                     rlast_q  <= ((r_cnt_q + 8'd1) == r_len_q);
                  end
               end
            end
            default: begin
               arready_q <= 1'b0;
               rvalid_q  <= 1'b0;
               rlast_q   <= 1'b0;
               r_state_q <= R_IDLE;
            end
         endcase
      end
   end

   assign awready = awready_q;
   assign wready  = wready_q;
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;
   assign arready = arready_q;
   assign rvalid  = rvalid_q;
   assign rlast   = rlast_q;
   assign rresp   = rresp_q;
   assign rdata   = rdata_q;

endmodule

// File: tb/tb_axi_burst_slave_mem.sv
// Directed bench for axi_burst_slave_mem: a word-level memory model predicts every read beat
// and write response, and a negedge compare process checks the DUT against it.
module tb_axi_burst_slave_mem;
   localparam int DEPTH = 64;
   localparam logic [31:0] BASE = 32'h0;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b1;
   logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
   logic [7:0]  awlen = '0, arlen = '0;
   logic [1:0]  awburst = '0, arburst = '0;
   logic        awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
   logic        arvalid = 1'b0, rready = 1'b0;
   logic [3:0]  wstrb = '0;
   logic        awready, wready, bvalid, arready, rvalid, rlast;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;

   axi_burst_slave_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arlen(arlen), .arburst(arburst), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } rbeat_t;

   rbeat_t      exp_r [$];
   logic [1:0]  exp_b [$];
   logic [31:0] model_mem [DEPTH];
   logic [31:0] wbuf [64];
   logic [3:0]  sbuf [64];
   logic [31:0] rx [64];
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic model_bad(input int len, input logic [1:0] burst);
      return (burst == 2'b11) ||
             ((burst == 2'b10) && !(len == 1 || len == 3 || len == 7 || len == 15));
   endfunction

   // Address of beat k, straight from the burst definitions
   function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                             input logic [1:0] burst, input int k);
      logic [31:0] span, lo;
      if (burst == 2'b00) return start;
      if (burst == 2'b10 && !model_bad(len, burst)) begin
         span = 32'(4 * (len + 1));
         lo   = start - (start % span);
         return lo + ((start - lo + 32'(4 * k)) % span);
      end
      return start + 32'(4 * k);
   endfunction

   function automatic logic model_in_range(input logic [31:0] a);
      return (a >= BASE) && (((a - BASE) / 32'd4) < 32'(DEPTH));
   endfunction

   // Compare process: every cycle a response or read beat is presented
   always @(negedge aclk) begin
      if (aresetn) begin
         if (rvalid) begin
            if (exp_r.size() == 0) begin
               check("r_unexpected", 32'(rvalid), 32'd0);
            end else begin
               check("rdata", rdata, exp_r[0].data);
               check("rresp", 32'(rresp), 32'(exp_r[0].resp));
               check("rlast", 32'(rlast), 32'(exp_r[0].last));
               if (rready) exp_r.delete(0);
            end
         end
         if (bvalid) begin
            check("awready_during_b", 32'(awready), 32'd0);
            if (exp_b.size() == 0) begin
               check("b_unexpected", 32'(bvalid), 32'd0);
            end else begin
               check("bresp", 32'(bresp), 32'(exp_b[0]));
               if (bready) exp_b.delete(0);
            end
         end
      end
   end

   task automatic wait_sig(input string name, input int which);
      int to;
      logic s;
      to = 0;
      @(negedge aclk);
      s = (which == 0) ? awready : (which == 1) ? wready : (which == 2) ? arready : (bvalid && bready);
      while (!s && to < 50) begin
         @(negedge aclk);
         to++;
         s = (which == 0) ? awready : (which == 1) ? wready : (which == 2) ? arready : (bvalid && bready);
      end
      if (!s) check(name, 32'd0, 32'd1);
   endtask

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int idx;
      idx = int'((a - BASE) / 32'd4);
      for (int b = 0; b < 4; b++) if (s[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
   endtask

   task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input int last_at, input int bhold);
      logic        err;
      logic [31:0] a;
      err = model_bad(len, burst);
      @(posedge aclk); #1;
      awaddr = addr; awlen = 8'(len); awburst = burst; awvalid = 1'b1;
      wait_sig("aw_timeout", 0);
      @(posedge aclk); #1;
      awvalid = 1'b0;
      for (int k = 0; k <= len; k++) begin
         wdata = wbuf[k]; wstrb = sbuf[k]; wlast = (k == last_at); wvalid = 1'b1;
         wait_sig("w_timeout", 1);
         a = beat_addr(addr, len, burst, k);
         if (model_in_range(a)) model_write(a, wbuf[k], sbuf[k]);
         else err = 1'b1;
         if ((k == last_at) != (k == len)) err = 1'b1;
         @(posedge aclk); #1;
      end
      wvalid = 1'b0; wlast = 1'b0;
      exp_b.push_back(err ? 2'b10 : 2'b00);
      repeat (bhold) @(posedge aclk);
      #1 bready = 1'b1;
      wait_sig("b_timeout", 3);
      @(posedge aclk); #1;
      bready = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input int toggle);
      rbeat_t      e;
      logic [31:0] a;
      int          n, cyc;
      for (int k = 0; k <= len; k++) begin
         a = beat_addr(addr, len, burst, k);
         if (!model_bad(len, burst) && model_in_range(a)) begin
            e.data = model_mem[int'((a - BASE) / 32'd4)]; e.resp = 2'b00;
         end else begin
            e.data = 32'd0; e.resp = 2'b10;
         end
         e.last = (k == len);
         exp_r.push_back(e);
      end
      @(posedge aclk); #1;
      araddr = addr; arlen = 8'(len); arburst = burst; arvalid = 1'b1;
      wait_sig("ar_timeout", 2);
      @(posedge aclk); #1;
      arvalid = 1'b0;
      n = 0; cyc = 0;
      while (n <= len && cyc < 300) begin
         rready = (toggle == 0) ? 1'b1 : ((cyc % 2) == 1);
         @(negedge aclk);
         if (rvalid && rready) begin
            rx[n] = rdata;
            n++;
         end
         @(posedge aclk); #1;
         cyc++;
      end
      rready = 1'b0;
      if (n <= len) check("r_timeout", 32'(n), 32'(len + 1));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_awready"}, 32'(awready), 32'd0);
      check({tag, "_wready"},  32'(wready),  32'd0);
      check({tag, "_bvalid"},  32'(bvalid),  32'd0);
      check({tag, "_bresp"},   32'(bresp),   32'd0);
      check({tag, "_arready"}, 32'(arready), 32'd0);
      check({tag, "_rvalid"},  32'(rvalid),  32'd0);
      check({tag, "_rlast"},   32'(rlast),   32'd0);
      check({tag, "_rresp"},   32'(rresp),   32'd0);
      check({tag, "_rdata"},   rdata,        32'd0);
   endtask

   initial begin
      #1 aresetn = 1'b0;
      repeat (2) @(negedge aclk);
      check_all_zero("reset");
      @(posedge aclk); #1 aresetn = 1'b1;
      @(negedge aclk);
      check("awready_first_cycle", 32'(awready), 32'd0);
      check("arready_first_cycle", 32'(arready), 32'd0);
      @(posedge aclk); #1;
      check("awready_rise", 32'(awready), 32'd1);
      check("arready_rise", 32'(arready), 32'd1);

      for (int i = 0; i < 64; i++) begin wbuf[i] = 32'h5A00_0000 | 32'(i); sbuf[i] = 4'hF; end
      do_write(32'h0, 63, 2'b01, 63, 0);

      wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
      do_write(32'h10, 3, 2'b01, 3, 0);
      do_read(32'h10, 3, 2'b01, 0);
      check("incr_b0", rx[0], 32'h11); check("incr_b1", rx[1], 32'h22);
      check("incr_b2", rx[2], 32'h33); check("incr_b3", rx[3], 32'h44);

      check("wrap_a0", beat_addr(32'h18, 3, 2'b10, 0), 32'h18);
      check("wrap_a1", beat_addr(32'h18, 3, 2'b10, 1), 32'h1C);
      check("wrap_a2", beat_addr(32'h18, 3, 2'b10, 2), 32'h10);
      check("wrap_a3", beat_addr(32'h18, 3, 2'b10, 3), 32'h14);
      wbuf[0] = 32'hA0; wbuf[1] = 32'hA1; wbuf[2] = 32'hA2; wbuf[3] = 32'hA3;
      do_write(32'h18, 3, 2'b10, 3, 0);
      do_read(32'h18, 3, 2'b10, 0);
      do_read(32'h10, 3, 2'b01, 0);
      check("wrap_w10", rx[0], 32'hA2); check("wrap_w14", rx[1], 32'hA3);
      check("wrap_w18", rx[2], 32'hA0); check("wrap_w1c", rx[3], 32'hA1);

      wbuf[0] = 32'hB0; wbuf[1] = 32'hB1; wbuf[2] = 32'hB2;
      do_write(32'h20, 2, 2'b10, 2, 0);
      do_read(32'h20, 2, 2'b01, 0);
      do_read(32'h20, 2, 2'b10, 0);

      wbuf[0] = 32'hFFFF_FFFF; sbuf[0] = 4'hF;
      do_write(32'h0, 0, 2'b01, 0, 0);
      wbuf[0] = 32'hAABB_CCDD; sbuf[0] = 4'b0101;
      do_write(32'h0, 0, 2'b01, 0, 0);
      sbuf[0] = 4'hF;
      do_read(32'h0, 0, 2'b01, 0);
      check("strobe_merge", rx[0], 32'hFFBB_FFDD);

      wbuf[0] = 32'hDEAD_0000; wbuf[1] = 32'hDEAD_0001;
      do_write(32'(DEPTH * 4), 1, 2'b01, 1, 0);
      do_read(32'(DEPTH * 4), 1, 2'b01, 0);
      do_read(32'(DEPTH * 4 - 8), 1, 2'b01, 0);
      check("oob_keep_62", rx[0], 32'h5A00_003E);
      check("oob_keep_63", rx[1], 32'h5A00_003F);

      wbuf[0] = 32'hC0DE_0001; wbuf[1] = 32'hC0DE_0002;
      do_write(32'h60, 1, 2'b01, 1, 5);
      do_read(32'h60, 3, 2'b01, 1);

      wbuf[0] = 32'h70; wbuf[1] = 32'h71; wbuf[2] = 32'h72; wbuf[3] = 32'h73;
      do_write(32'h80, 3, 2'b01, 1, 0);

      wbuf[0] = 32'h1; wbuf[1] = 32'h2; wbuf[2] = 32'h3;
      do_write(32'h30, 2, 2'b00, 2, 0);
      do_read(32'h30, 1, 2'b00, 0);
      check("fixed_b0", rx[0], 32'h3); check("fixed_b1", rx[1], 32'h3);

      do_read(32'h40, 0, 2'b11, 0);

      // Reset after two of four write beats
      @(posedge aclk); #1;
      awaddr = 32'h40; awlen = 8'd3; awburst = 2'b01; awvalid = 1'b1;
      wait_sig("aw_timeout_rst", 0);
      @(posedge aclk); #1;
      awvalid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         wdata = 32'hE000_0000 | 32'(k); wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
         wait_sig("w_timeout_rst", 1);
         model_write(32'h40 + 32'(4 * k), wdata, 4'hF);
         @(posedge aclk); #1;
      end
      #2 aresetn = 1'b0; wvalid = 1'b0;
      #1 check_all_zero("midrst");
      repeat (2) @(posedge aclk);
      #1 aresetn = 1'b1;
      @(negedge aclk);
      check("midrst_awready_low", 32'(awready), 32'd0);
      @(posedge aclk); #1;
      check("midrst_awready_rise", 32'(awready), 32'd1);
      do_read(32'h40, 3, 2'b01, 0);
      check("midrst_w0", rx[0], 32'hE000_0000); check("midrst_w1", rx[1], 32'hE000_0001);
      check("midrst_w2", rx[2], 32'h5A00_0012); check("midrst_w3", rx[3], 32'h5A00_0013);

      repeat (3) @(posedge aclk);
      check("exp_r_drained", 32'(exp_r.size()), 32'd0);
      check("exp_b_drained", 32'(exp_b.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
